// File: rtl/axi4s_pkt_reader.sv
// axi4s_pkt_reader: takes {addr, len} descriptors, reads len words from a
// 1-cycle-latency packet RAM and streams them out on AXI4-Stream with tlast
// on the final beat. A 2-entry skid FIFO decouples RAM latency from tready.
// Optional: define AXI4S_PKT_READER_STATS_EN to add pkt_cnt_o (tlast count).
module axi4s_pkt_reader #(
  parameter int AXI_WIDTH  = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] desc_addr_i,
  input  logic [LEN_WIDTH-1:0]  desc_len_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [AXI_WIDTH-1:0]  rd_data_i,
`ifdef AXI4S_PKT_READER_STATS_EN
  output logic [31:0]           pkt_cnt_o,
`endif
  output logic [AXI_WIDTH-1:0]  s_tdata_o,
  output logic                  s_tvalid_o,
  input  logic                  s_tready_i,
  output logic                  s_tlast_o
);

  typedef enum logic {IDLE, READ} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic                  infl_q, infl_d;          // RAM word arriving this cycle
  logic                  infl_last_q, infl_last_d;
  logic [AXI_WIDTH-1:0]  fifo_data_q [2];
  logic [AXI_WIDTH-1:0]  fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  pop;
  logic                  head_last;
  logic [2:0]            occ;
  logic                  rd_en;

  // Occupancy seen by the next read includes the word in flight and credits
  // this cycle's pop, so back-to-back reads sustain 1 beat/cycle.
  assign pop       = (cnt_q != 2'd0) && s_tready_i;
  assign head_last = fifo_last_q[rd_ptr_q];
  assign occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_en     = (state_q == READ) && (beats_q != '0) && (occ < 3'd2);

  // Ready is masked by reset so nothing is accepted while held in reset.
  assign desc_ready_o = (state_q == IDLE) && rst_ni;
  assign rd_en_o      = rd_en;
  assign rd_addr_o    = addr_q;
  assign s_tvalid_o   = (cnt_q != 2'd0);
  assign s_tdata_o    = fifo_data_q[rd_ptr_q];
  assign s_tlast_o    = s_tvalid_o && head_last;

  // Next-state: descriptor intake, read issue, FIFO push/pop.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    infl_d      = rd_en;
    infl_last_d = rd_en && (beats_q == LEN_WIDTH'(1));
    cnt_d       = cnt_q + {1'b0, infl_q} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (desc_valid_i && desc_ready_o) begin
          addr_d  = desc_addr_i;
          beats_d = desc_len_i;
          if (desc_len_i != '0) state_d = READ;
        end
      end
      READ: begin
        if (rd_en) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - LEN_WIDTH'(1);
        end
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (infl_q) begin
      fifo_data_d[wr_ptr_q] = rd_data_i;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // State register; reset drops any packet and in-flight RAM data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      beats_q        <= '0;
      infl_q         <= 1'b0;
      infl_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef AXI4S_PKT_READER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  // Count completed packets (tlast handshakes); wraps naturally.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + 32'(pop && head_last);
  end

  // Packet counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pkt_cnt_q <= '0;
    else         pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axi4s_pkt_reader.sv
// Bench for axi4s_pkt_reader: packet vector table, hand-written timing and
// reset sequences, and randomized descriptors/tready checked by a monitor
// against a queue of expected reads and beats derived from each descriptor.
module tb_axi4s_pkt_reader;
  localparam int AW  = 64;
  localparam int ADW = 10;
  localparam int LW  = 11;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [ADW-1:0] desc_addr_i;
  logic [LW-1:0]  desc_len_i;
  logic           desc_valid_i;
  logic           desc_ready_o;
  logic           rd_en_o;
  logic [ADW-1:0] rd_addr_o;
  logic [AW-1:0]  rd_data_i;
  logic [AW-1:0]  s_tdata_o;
  logic           s_tvalid_o;
  logic           s_tready_i;
  logic           s_tlast_o;
`ifdef AXI4S_PKT_READER_STATS_EN
  logic [31:0]    pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  axi4s_pkt_reader #(.AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
`ifdef AXI4S_PKT_READER_STATS_EN
    .pkt_cnt_o(pkt_cnt_o),
`endif
    .s_tdata_o(s_tdata_o), .s_tvalid_o(s_tvalid_o),
    .s_tready_i(s_tready_i), .s_tlast_o(s_tlast_o)
  );

  // RAM contents: a fixed function of the address
  function automatic logic [AW-1:0] ram_val(input logic [ADW-1:0] a);
    logic [31:0] h;
    h = {22'd0, a} * 32'h9E3779B9;
    return {a, 22'h2AAAAA, h};
  endfunction

  // RAM with 1-cycle read latency; garbage when not read
  always @(posedge clk) rd_data_i <= rd_en_o ? ram_val(rd_addr_o) : 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct { logic [AW-1:0] data; logic last; } beat_t;
  beat_t          exp_beat_q[$];
  logic [ADW-1:0] exp_addr_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_reads, n_pops, pkt_beats, pkt_tlasts;
  logic [ADW-1:0] last_rd_addr;
  logic           hold_vld;
  logic [AW-1:0]  hold_data;
  logic           hold_last;
  int             rdy_mode;   // 0: always ready, 1: pattern while valid, 2: random
  logic [7:0]     pat_bits;
  int             pat_len, pat_idx;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Monitor: reset outputs, read addresses, beats, stall stability, occupancy
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_vld = 1'b0;
      chk("rst_tvalid", s_tvalid_o, 0);
      chk("rst_tlast", s_tlast_o, 0);
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_desc_ready", desc_ready_o, 0);
    end else begin
      if (hold_vld) begin
        chk("stall_tvalid", s_tvalid_o, 1);
        chk("stall_tdata", s_tdata_o, hold_data);
        chk("stall_tlast", s_tlast_o, hold_last);
      end
      hold_vld = 1'b0;
      chk("occupancy_le2", ((n_reads - n_pops) <= 2), 1);
      if (rd_en_o) begin
        if (exp_addr_q.size() == 0) flag_fail("unexpected_read");
        else chk("rd_addr", rd_addr_o, exp_addr_q.pop_front());
        last_rd_addr = rd_addr_o;
        n_reads++;
      end
      if (s_tvalid_o) begin
        if (s_tready_i) begin
          if (exp_beat_q.size() == 0) flag_fail("unexpected_beat");
          else begin
            beat_t b;
            b = exp_beat_q.pop_front();
            chk("beat_data", s_tdata_o, b.data);
            chk("beat_last", s_tlast_o, b.last);
          end
          n_pops++;
          pkt_beats++;
          if (s_tlast_o) pkt_tlasts++;
        end else begin
          hold_vld  = 1'b1;
          hold_data = s_tdata_o;
          hold_last = s_tlast_o;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: s_tready_i = 1'b1;
      1: begin
        if (s_tvalid_o) begin
          s_tready_i = pat_bits[pat_idx % pat_len];
          pat_idx++;
        end else s_tready_i = 1'b0;
      end
      default: s_tready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Offer a descriptor; returns just after the handshake edge
  task automatic send_desc(input logic [ADW-1:0] a, input logic [LW-1:0] len);
    int cnt;
    desc_addr_i  = a;
    desc_len_i   = len;
    desc_valid_i = 1'b1;
    cnt = 0;
    while (!desc_ready_o && cnt < 100) begin step(); cnt++; end
    if (cnt == 100) flag_fail("desc_ready_timeout");
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      logic [ADW-1:0] ai;
      ai     = a + ADW'(i);
      b.data = ram_val(ai);
      b.last = (i == int'(len) - 1);
      exp_addr_q.push_back(ai);
      exp_beat_q.push_back(b);
    end
    pkt_beats  = 0;
    pkt_tlasts = 0;
    step();
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    repeat (3) step();
    cnt = 0;
    while ((exp_beat_q.size() != 0 || !desc_ready_o) && cnt < 300) begin step(); cnt++; end
    if (cnt == 300) flag_fail("packet_done_timeout");
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    exp_beat_q.delete();
    exp_addr_q.delete();
    n_reads = 0;
    n_pops  = 0;
    repeat (3) step();
    rst_ni = 1'b1;
    #1;
    chk("desc_ready_after_reset", desc_ready_o, 1);
  endtask

  typedef struct {
    logic [ADW-1:0] addr;
    logic [LW-1:0]  len;
    logic [7:0]     pat;
    int             pat_len;
    int             mode;
    int             exp_beats;
    int             exp_tlasts;
    logic [ADW-1:0] exp_last_addr;
  } vec_t;

  typedef struct { logic rden; logic [ADW-1:0] addr; logic tvalid; logic tlast; logic ready; } cyc_t;

  vec_t vecs[7];
  cyc_t tim[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr:10'h010, len:11'd4, pat:8'h00, pat_len:1, mode:0, exp_beats:4, exp_tlasts:1, exp_last_addr:10'h013};
    vecs[1] = '{addr:10'h020, len:11'd3, pat:8'b0010_1001, pat_len:6, mode:1, exp_beats:3, exp_tlasts:1, exp_last_addr:10'h022};
    vecs[2] = '{addr:10'h3FE, len:11'd4, pat:8'h00, pat_len:1, mode:0, exp_beats:4, exp_tlasts:1, exp_last_addr:10'h001};
    vecs[3] = '{addr:10'h100, len:11'd0, pat:8'h00, pat_len:1, mode:0, exp_beats:0, exp_tlasts:0, exp_last_addr:10'h000};
    vecs[4] = '{addr:10'h155, len:11'd1, pat:8'h00, pat_len:1, mode:0, exp_beats:1, exp_tlasts:1, exp_last_addr:10'h155};
    vecs[5] = '{addr:10'h3FF, len:11'd5, pat:8'b0101_0101, pat_len:8, mode:1, exp_beats:5, exp_tlasts:1, exp_last_addr:10'h003};
    vecs[6] = '{addr:10'h200, len:11'd2, pat:8'h00, pat_len:1, mode:2, exp_beats:2, exp_tlasts:1, exp_last_addr:10'h201};

    // Cycles after handshake edge k of {0x010, 4} with tready high
    tim[0] = '{rden:1, addr:10'h010, tvalid:0, tlast:0, ready:0};
    tim[1] = '{rden:1, addr:10'h011, tvalid:0, tlast:0, ready:0};
    tim[2] = '{rden:1, addr:10'h012, tvalid:1, tlast:0, ready:0};
    tim[3] = '{rden:1, addr:10'h013, tvalid:1, tlast:0, ready:0};
    tim[4] = '{rden:0, addr:10'h000, tvalid:1, tlast:0, ready:0};
    tim[5] = '{rden:0, addr:10'h000, tvalid:1, tlast:1, ready:0};
    tim[6] = '{rden:0, addr:10'h000, tvalid:0, tlast:0, ready:1};

    rst_ni = 1'b1; desc_valid_i = 1'b0; desc_addr_i = '0; desc_len_i = '0;
    s_tready_i = 1'b1; rdy_mode = 0; pat_bits = '0; pat_len = 1; pat_idx = 0;
    n_reads = 0; n_pops = 0; pkt_beats = 0; pkt_tlasts = 0; hold_vld = 1'b0;
    last_rd_addr = '0;
    #2;
    do_reset();

    // Latency and throughput of a 4-beat packet
    rdy_mode = 0;
    send_desc(10'h010, 11'd4);
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("t%0d_rd_en", c), rd_en_o, tim[c].rden);
      if (tim[c].rden) chk($sformatf("t%0d_rd_addr", c), rd_addr_o, tim[c].addr);
      chk($sformatf("t%0d_tvalid", c), s_tvalid_o, tim[c].tvalid);
      chk($sformatf("t%0d_tlast", c), s_tlast_o, tim[c].tlast);
      chk($sformatf("t%0d_desc_ready", c), desc_ready_o, tim[c].ready);
      step();
    end
    wait_done();

    // Packet vector table
    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].mode;
      pat_bits = vecs[v].pat;
      pat_len  = vecs[v].pat_len;
      pat_idx  = 0;
      send_desc(vecs[v].addr, vecs[v].len);
      wait_done();
      chk($sformatf("vec%0d_beats", v), pkt_beats, vecs[v].exp_beats);
      chk($sformatf("vec%0d_tlasts", v), pkt_tlasts, vecs[v].exp_tlasts);
      if (vecs[v].exp_beats > 0) chk($sformatf("vec%0d_last_rd_addr", v), last_rd_addr, vecs[v].exp_last_addr);
    end

    // Reset in the middle of a len-8 packet after beat 2
    rdy_mode = 0;
    send_desc(10'h050, 11'd8);
    begin
      int cnt;
      cnt = 0;
      while (pkt_beats < 2 && cnt < 50) begin step(); cnt++; end
      if (cnt == 50) flag_fail("midpkt_beat2_timeout");
    end
    rst_ni = 1'b0;
    exp_beat_q.delete();
    exp_addr_q.delete();
    n_reads = 0;
    n_pops  = 0;
    #1;
    chk("midrst_tvalid", s_tvalid_o, 0);
    chk("midrst_tlast", s_tlast_o, 0);
    chk("midrst_rd_en", rd_en_o, 0);
    repeat (2) step();
    rst_ni = 1'b1;
    #1;
    chk("midrst_desc_ready", desc_ready_o, 1);
    repeat (10) step();
    chk("midrst_no_tlast", pkt_tlasts, 0);
    chk("midrst_beats", pkt_beats, 2);

    // Randomized descriptors and tready
    rdy_mode = 2;
    for (int r = 0; r < 40; r++) begin
      logic [ADW-1:0] ra;
      logic [LW-1:0]  rl;
      ra = ADW'($urandom_range(0, 1023));
      rl = LW'($urandom_range(0, 12));
      send_desc(ra, rl);
      wait_done();
      chk($sformatf("rnd%0d_beats", r), pkt_beats, int'(rl));
      chk($sformatf("rnd%0d_tlasts", r), pkt_tlasts, (rl != 0) ? 1 : 0);
    end

`ifdef AXI4S_PKT_READER_STATS_EN
    rdy_mode = 0;
    do_reset();
    chk("stats_reset", pkt_cnt_o, 0);
    send_desc(10'h030, 11'd2); wait_done();
    send_desc(10'h040, 11'd1); wait_done();
    send_desc(10'h050, 11'd3); wait_done();
    chk("stats_three", pkt_cnt_o, 3);
    @(negedge clk);
    dut.pkt_cnt_q = 32'hFFFF_FFFF;
    step();
    send_desc(10'h060, 11'd2); wait_done();
    chk("stats_wrap", pkt_cnt_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4s_pkt_reader.md
AXI4S_PKT_READER -- requirements
Module: axi4s_pkt_reader

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 64, tdata and RAM data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, packet-buffer RAM word address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 11, descriptor length width in beats.
REQ-004 SHALL have clk_i  in  1  sole clock; one clock; all logic on its rising edge.
REQ-005 SHALL have rst_ni  in  1  reset; asynchronous and active-low.
REQ-006 SHALL have desc_addr_i  in  ADDR_WIDTH  packet start word address.
REQ-007 SHALL have desc_len_i  in  LEN_WIDTH  packet length in beats.
REQ-008 SHALL have desc_valid_i  in  1  descriptor valid.
REQ-009 SHALL have desc_ready_o  out  1  descriptor accept.
REQ-010 SHALL have rd_en_o  out  1  RAM read strobe.
REQ-011 SHALL have rd_addr_o  out  ADDR_WIDTH  RAM read address.
REQ-012 SHALL have rd_data_i  in  AXI_WIDTH  RAM read data, valid exactly one cycle after rd_en_o.
REQ-013 SHALL have s_tdata_o  out  AXI_WIDTH  downstream AXI4-Stream data.
REQ-014 SHALL have s_tvalid_o  out  1  downstream valid.
REQ-015 SHALL have s_tready_i  in  1  downstream ready.
REQ-016 SHALL have s_tlast_o  out  1  final beat of packet.

Function
REQ-017 SHALL implement states IDLE and READ; desc_ready_o = 1 only in IDLE.
REQ-018 SHALL, on desc_valid_i && desc_ready_o, latch address and length; if length nonzero, enter READ; if zero, discard and stay IDLE, with no RAM reads and no beats.
REQ-019 SHALL, in READ, assert rd_en_o when beats_left > 0 && (buf_occ + inflight - pop) < 2, with pop = s_tvalid_o && s_tready_i, and decrement beats_left per read.
REQ-020 SHALL increment rd_addr_o by 1 per read, wrapping modulo 2^ADDR_WIDTH (0x3FF -> 0x000 at default).
REQ-021 SHALL tag each read with a last flag when beats_left == 1, and capture rd_data_i and the flag into a 2-entry output FIFO one cycle after rd_en_o.
REQ-022 SHALL drive s_tdata_o, s_tvalid_o and s_tlast_o only from the FIFO head, with no combinational path from s_tready_i to s_tvalid_o or s_tdata_o.
REQ-023 SHALL hold s_tdata_o and s_tlast_o stable while s_tvalid_o && !s_tready_i.
REQ-024 SHALL, for a descriptor handshake at edge k with s_tready_i held high, assert rd_en_o after edge k and first s_tvalid_o after edge k+2.
REQ-025 SHALL sustain 1 beat/cycle within a packet while s_tready_i is high, and SHALL never overflow the FIFO under any s_tready_i pattern.
REQ-026 SHALL return to IDLE on the edge where the tlast beat handshakes, with desc_ready_o = 1 in the following cycle.
REQ-027 SHALL assert s_tlast_o on exactly one beat per nonzero-length packet; a length-1 packet is a single beat with s_tlast_o = 1.

Reset
REQ-028 SHALL, while rst_ni = 0, force IDLE, an empty FIFO, inflight = 0, s_tvalid_o = 0, s_tlast_o = 0, rd_en_o = 0 and desc_ready_o = 0.
REQ-029 SHALL, on assertion of rst_ni mid-packet, abandon the packet: no further beats, no tlast, and any inflight RAM data discarded.
REQ-030 SHALL drive desc_ready_o = 1 in the first cycle after rst_ni deasserts.

Configuration
REQ-031 SHALL, with macro AXI4S_PKT_READER_STATS_EN defined, add output pkt_cnt_o (32 bits, reset 0), which increments on each tlast handshake and wraps 0xFFFFFFFF -> 0.
REQ-032 SHALL, without AXI4S_PKT_READER_STATS_EN, have no pkt_cnt_o port and no counter logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: desc addr 0x010, len 4, tready = 1 -> rd_addr_o 0x010..0x013 on consecutive cycles; 4 back-to-back beats with RAM data; tlast on beat 4; desc_ready_o = 1 the next cycle.
REQ-034 SHALL cover: len 3 with tready toggling 1,0,0,1,0,1 -> 3 beats in order, data stable while stalled, FIFO never exceeds 2 entries.
REQ-035 SHALL cover: addr 0x3FE, len 4 -> reads 0x3FE, 0x3FF, 0x000, 0x001.
REQ-036 SHALL cover: len 0 descriptor, then len 1 descriptor -> no beats for the first; a single beat with tlast for the second.
REQ-037 SHALL cover: rst_ni pulsed low after beat 2 of a len-8 packet -> s_tvalid_o = 0 immediately; no tlast; desc_ready_o = 1 after release.
REQ-038 SHALL cover, with AXI4S_PKT_READER_STATS_EN defined: 3 packets sent -> pkt_cnt_o = 3; counter preset to 0xFFFFFFFF plus 1 packet -> pkt_cnt_o = 0.
